// File: rtl/audio_clk_gen_pkg.sv
// rtl/audio_clk_gen_pkg.sv - shared types and constants for the audio clock generator
package audio_clk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic FS_MODE_LRCK  = 1'b0;
   localparam logic FS_MODE_PULSE = 1'b1;

endpackage

// File: rtl/audio_clk_gen_if.sv
// rtl/audio_clk_gen_if.sv - configuration and clock/status bundle for audio_clk_gen
interface audio_clk_gen_if #(
   parameter int DIV_W     = 8,
   parameter int MAX_SLOTS = 8,
   parameter int SLOT_W    = 6
);
   logic                         en;
   logic [DIV_W-1:0]             bclk_div;
   logic [SLOT_W-1:0]            slot_bits;
   logic [$clog2(MAX_SLOTS):0]   num_slots;
   logic                         fs_mode;
   logic                         bclk;
   logic                         word_clk;
   logic                         frame_start;
   logic [$clog2(MAX_SLOTS)-1:0] slot_idx;
   logic [SLOT_W-1:0]            bit_idx;
   logic                         busy;

   modport master (
      output en, bclk_div, slot_bits, num_slots, fs_mode,
      input  bclk, word_clk, frame_start, slot_idx, bit_idx, busy
   );

   modport slave (
      input  en, bclk_div, slot_bits, num_slots, fs_mode,
      output bclk, word_clk, frame_start, slot_idx, bit_idx, busy
   );
endinterface

// File: rtl/audio_clk_gen_div.sv
// rtl/audio_clk_gen_div.sv - mclk counter producing a 50% duty bclk and an end-of-bit tick
module audio_clk_div #(
   parameter int DIV_W = 8
) (
   input  logic             mclkin,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] d,
   output logic             bclk,
   output logic             bit_tick
);
   logic [DIV_W-1:0] mc;
   logic [DIV_W-1:0] half;
   logic             last;

   assign half     = d >> 1;
   assign last     = (mc == d - DIV_W'(1));
   assign bit_tick = run && last;

   // d is always even and >= 2, so the set and clear points never coincide.
   always_ff @(posedge mclkin or negedge rst_n) begin
      if (!rst_n) begin
         mc   <= '0;
         bclk <= 1'b0;
      end else if (!run) begin
         mc   <= '0;
         bclk <= 1'b0;
      end else begin
         if (last) begin
            mc   <= '0;
            bclk <= 1'b0;
         end else begin
            mc <= mc + DIV_W'(1);
            if (mc == half - DIV_W'(1)) begin
               bclk <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/audio_clk_gen.sv
// rtl/audio_clk_gen.sv - I2S/TDM bit clock, word clock and slot/bit position generator
module audio_clk_gen
   import audio_clk_pkg::*;
#(
   parameter int DIV_W     = 8,
   parameter int MAX_SLOTS = 8,
   parameter int SLOT_W    = 6
) (
   input  logic                         mclkin,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [DIV_W-1:0]             bclk_div,
   input  logic [SLOT_W-1:0]            slot_bits,
   input  logic [$clog2(MAX_SLOTS):0]   num_slots,
   input  logic                         fs_mode,
   output logic                         bclk,
   output logic                         word_clk,
   output logic                         frame_start,
   output logic [$clog2(MAX_SLOTS)-1:0] slot_idx,
   output logic [SLOT_W-1:0]            bit_idx,
   output logic                         busy
);
   localparam int SI_W = $clog2(MAX_SLOTS);
   localparam int NS_W = SI_W + 1;
   localparam int FB_W = SLOT_W + NS_W;

   state_t            state;
   logic [DIV_W-1:0]  d_lat;
   logic [SLOT_W-1:0] s_lat;
   logic [NS_W-1:0]   n_lat;
   logic [FB_W-1:0]   f_lat;
   logic              mode_lat;
   logic [FB_W-1:0]   fbit;

   logic [DIV_W-1:0]  d_eff;
   logic [SLOT_W-1:0] s_eff;
   logic [NS_W-1:0]   n_eff;
   logic [FB_W-1:0]   f_eff;
   logic [FB_W-1:0]   fbit_nxt;
   logic              bit_tick;
   logic              last_bit;
   logic              last_slot;
   logic              boundary;
   logic              start;
   logic              stop;

   function automatic logic wc_level(input logic mode, input logic [FB_W-1:0] fb,
                                     input logic [FB_W-1:0] f);
      if (mode == FS_MODE_PULSE) begin
         return (fb == '0);
      end
      return (fb >= (f >> 1));
   endfunction

   always_comb begin
      d_eff = bclk_div & ~DIV_W'(1);
      if (d_eff < DIV_W'(2)) begin
         d_eff = DIV_W'(2);
      end
      s_eff = (slot_bits == '0) ? SLOT_W'(1) : slot_bits;
      n_eff = num_slots;
      if (n_eff == '0) begin
         n_eff = NS_W'(1);
      end else if (n_eff > NS_W'(MAX_SLOTS)) begin
         n_eff = NS_W'(MAX_SLOTS);
      end
      f_eff = FB_W'(n_eff) * FB_W'(s_eff);
   end

   assign fbit_nxt  = fbit + FB_W'(1);
   assign last_bit  = (bit_idx == s_lat - SLOT_W'(1));
   assign last_slot = ({1'b0, slot_idx} == n_lat - NS_W'(1));
   assign boundary  = bit_tick && last_bit && last_slot;

   // A new frame starts from IDLE or back-to-back at a boundary; leaving is only ever at a boundary.
   assign start = (state == ST_IDLE) ? en : (boundary && en);
   assign stop  = (state != ST_IDLE) && boundary && !en;

   audio_clk_div #(
      .DIV_W (DIV_W)
   ) u_div (
      .mclkin   (mclkin),
      .rst_n    (rst_n),
      .run      (state != ST_IDLE),
      .d        (d_lat),
      .bclk     (bclk),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge mclkin or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         word_clk    <= 1'b0;
         bit_idx     <= '0;
         slot_idx    <= '0;
         fbit        <= '0;
         d_lat       <= DIV_W'(2);
         s_lat       <= SLOT_W'(1);
         n_lat       <= NS_W'(1);
         f_lat       <= FB_W'(1);
         mode_lat    <= FS_MODE_LRCK;
      end else begin
         frame_start <= 1'b0;
         if (start) begin
            state       <= ST_RUN;
            busy        <= 1'b1;
            frame_start <= 1'b1;
            bit_idx     <= '0;
            slot_idx    <= '0;
            fbit        <= '0;
            d_lat       <= d_eff;
            s_lat       <= s_eff;
            n_lat       <= n_eff;
            f_lat       <= f_eff;
            mode_lat    <= fs_mode;
            word_clk    <= wc_level(fs_mode, '0, f_eff);
         end else if (stop) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            word_clk <= 1'b0;
            bit_idx  <= '0;
            slot_idx <= '0;
            fbit     <= '0;
         end else begin
            case (state)
               ST_RUN:   if (!en) state <= ST_DRAIN;
               ST_DRAIN: if (en)  state <= ST_RUN;
               default:  state <= ST_IDLE;
            endcase
            if (bit_tick) begin
               fbit     <= fbit_nxt;
               word_clk <= wc_level(mode_lat, fbit_nxt, f_lat);
               if (last_bit) begin
                  bit_idx  <= '0;
                  slot_idx <= slot_idx + SI_W'(1);
               end else begin
                  bit_idx <= bit_idx + SLOT_W'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_audio_clk_gen.sv
// tb/tb_audio_clk_gen.sv - scoreboard bench: expected frames queued by stimulus, measured by a monitor
module tb_audio_clk_gen;
   logic mclkin = 1'b0;
   logic rst_n  = 1'b0;

   always #5 mclkin = ~mclkin;

   audio_clk_gen_if #(.DIV_W(8), .MAX_SLOTS(8), .SLOT_W(6)) bus ();

   audio_clk_gen #(.DIV_W(8), .MAX_SLOTS(8), .SLOT_W(6)) dut (
      .mclkin      (mclkin),
      .rst_n       (rst_n),
      .en          (bus.en),
      .bclk_div    (bus.bclk_div),
      .slot_bits   (bus.slot_bits),
      .num_slots   (bus.num_slots),
      .fs_mode     (bus.fs_mode),
      .bclk        (bus.bclk),
      .word_clk    (bus.word_clk),
      .frame_start (bus.frame_start),
      .slot_idx    (bus.slot_idx),
      .bit_idx     (bus.bit_idx),
      .busy        (bus.busy)
   );

   typedef struct {
      int len;
      int wc_high;
      int rises;
      int first_rise;
      int max_slot;
      int wc_first;
   } frame_t;

   frame_t exp_q[$];
   int     checks   = 0;
   int     failures = 0;
   bit     abort_frame = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push(input int len, input int wch, input int rises, input int fr,
                       input int ms, input int wf);
      frame_t f;
      f.len = len; f.wc_high = wch; f.rises = rises;
      f.first_rise = fr; f.max_slot = ms; f.wc_first = wf;
      exp_q.push_back(f);
   endtask

   // Monitor: measures each frame between frame_start pulses (or busy dropping).
   frame_t m;
   bit     in_frame  = 1'b0;
   bit     prev_bclk = 1'b0;

   task automatic close_frame();
      frame_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_frame", 1, 0);
      end else begin
         e = exp_q.pop_front();
         check("frame_len", m.len, e.len);
         check("frame_wc_high", m.wc_high, e.wc_high);
         check("frame_bclk_rises", m.rises, e.rises);
         check("frame_first_rise", m.first_rise, e.first_rise);
         check("frame_max_slot", m.max_slot, e.max_slot);
         check("frame_wc_first", m.wc_first, e.wc_first);
      end
   endtask

   initial begin
      forever begin
         @(negedge mclkin);
         if (in_frame && (bus.frame_start || !bus.busy)) begin
            if (abort_frame) abort_frame = 1'b0;
            else close_frame();
            in_frame = 1'b0;
         end
         if (bus.frame_start) begin
            in_frame     = 1'b1;
            m.len        = 0;
            m.wc_high    = 0;
            m.rises      = 0;
            m.first_rise = -1;
            m.max_slot   = 0;
            m.wc_first   = int'(bus.word_clk);
         end
         if (in_frame) begin
            if (bus.bclk && !prev_bclk) begin
               m.rises++;
               if (m.first_rise < 0) m.first_rise = m.len;
            end
            m.wc_high += int'(bus.word_clk);
            if (int'(bus.slot_idx) > m.max_slot) m.max_slot = int'(bus.slot_idx);
            m.len++;
         end
         prev_bclk = bus.bclk;
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge mclkin);
   endtask

   task automatic cfg(input int div, input int s, input int n, input bit mode);
      bus.bclk_div  = div[7:0];
      bus.slot_bits = s[5:0];
      bus.num_slots = n[3:0];
      bus.fs_mode   = mode;
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(negedge mclkin);
         if (!bus.busy) break;
      end
      check("idle_reached", int'(bus.busy), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bclk"}, int'(bus.bclk), 0);
      check({tag, "_word_clk"}, int'(bus.word_clk), 0);
      check({tag, "_frame_start"}, int'(bus.frame_start), 0);
      check({tag, "_slot_idx"}, int'(bus.slot_idx), 0);
      check({tag, "_bit_idx"}, int'(bus.bit_idx), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
   endtask

   initial begin
      bus.en = 1'b0;
      cfg(4, 16, 2, 1'b0);
      hold(3);
      check_zero("reset");
      rst_n = 1'b1;
      hold(3);
      check("idle_without_en", int'(bus.busy), 0);

      // D=4 S=16 N=2 LRCK: 128-mclk frames, word_clk high for the second 64
      for (int i = 0; i < 3; i++) push(128, 64, 32, 2, 1, 0);
      bus.en = 1'b1; hold(296); bus.en = 1'b0;
      wait_idle(600); hold(2);

      // bclk_div=2 S=32 N=8 pulse mode: 512-mclk frames, 2-mclk sync pulse
      cfg(2, 32, 8, 1'b1);
      for (int i = 0; i < 2; i++) push(512, 2, 256, 1, 7, 1);
      bus.en = 1'b1; hold(552); bus.en = 1'b0;
      wait_idle(1200); hold(2);

      // odd and zero dividers both collapse to D=2
      cfg(3, 4, 1, 1'b0);
      for (int i = 0; i < 2; i++) push(8, 4, 4, 1, 0, 0);
      bus.en = 1'b1; hold(10); bus.en = 1'b0;
      wait_idle(100); hold(2);
      cfg(0, 4, 1, 1'b0);
      for (int i = 0; i < 2; i++) push(8, 4, 4, 1, 0, 0);
      bus.en = 1'b1; hold(10); bus.en = 1'b0;
      wait_idle(100); hold(2);

      // en dropped at bit 5: frame still completes, then everything is 0
      cfg(4, 16, 2, 1'b0);
      push(128, 64, 32, 2, 1, 0);
      bus.en = 1'b1; hold(21); bus.en = 1'b0;
      hold(4);
      check("drain_busy", int'(bus.busy), 1);
      wait_idle(300);
      check_zero("drained");
      hold(2);

      // slot_bits 16->24 mid-frame takes effect at the next frame only
      cfg(4, 16, 2, 1'b0);
      push(128, 64, 32, 2, 1, 0);
      push(192, 96, 48, 2, 1, 0);
      bus.en = 1'b1; hold(40); bus.slot_bits = 6'd24; hold(128); bus.en = 1'b0;
      wait_idle(500); hold(2);

      // en glitch low mid-frame: DRAIN returns to RUN without a gap
      cfg(4, 4, 2, 1'b0);
      for (int i = 0; i < 2; i++) push(32, 16, 8, 2, 1, 0);
      bus.en = 1'b1; hold(10); bus.en = 1'b0; hold(4);
      check("glitch_busy", int'(bus.busy), 1);
      bus.en = 1'b1; hold(26); bus.en = 1'b0;
      wait_idle(200); hold(2);

      // clamps: num_slots=15 -> 8, slot_bits=0 -> 1, bclk_div=1 -> 2
      cfg(1, 0, 15, 1'b0);
      push(16, 8, 8, 1, 7, 0);
      bus.en = 1'b1; hold(5); bus.en = 1'b0;
      wait_idle(100); hold(2);

      // asynchronous reset mid-frame while bclk is high, then restart
      cfg(4, 16, 2, 1'b0);
      bus.en = 1'b1; hold(40);
      for (int i = 0; i < 10; i++) begin
         if (bus.bclk) break;
         @(negedge mclkin);
      end
      check("pre_reset_bclk", int'(bus.bclk), 1);
      abort_frame = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      hold(2);
      push(128, 64, 32, 2, 1, 0);
      rst_n = 1'b1;
      @(negedge mclkin);
      check("restart_frame_start", int'(bus.frame_start), 1);
      hold(20); bus.en = 1'b0;
      wait_idle(300);
      hold(5);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
